// File: rtl/joker_spi_slave.sv
// SPI mode-0 target: oversampled SCLK/MOSI/nCS, 8-bit MSB-first words,
// RX bytes into a first-word fall-through FIFO, TX from a one-entry holding register.
module joker_spi_slave #(
    parameter int         RX_FIFO_DEPTH = 16,
    parameter logic [7:0] DUMMY_BYTE    = 8'hFF,
    parameter int         SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_ncs,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [7:0]  rx_data,
    output logic        rx_first,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        frame_active,
    output logic        frame_done,
    output logic [15:0] byte_count,
    output logic        rx_overflow,
    output logic        tx_underrun,
    input  logic        clr_status
);
    localparam int AW = $clog2(RX_FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
    state_t r_state, w_state_next;

    // pin order {ncs, mosi, sclk}; ncs synchroniser resets to its idle-high level
    logic [2:0] w_pin, w_sync;
    assign w_pin = {spi_ncs, spi_mosi, spi_sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk) begin
                if (reset) r_sync <= {SYNC_STAGES{gi == 2}};
                else       r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin[gi]};
            end
            assign w_sync[gi] = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    logic w_sclk, w_mosi, w_ncs;
    assign w_sclk = w_sync[0];
    assign w_mosi = w_sync[1];
    assign w_ncs  = w_sync[2];

    logic r_sclk_d, r_ncs_d;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_rx_shift, r_tx_shift, r_hold;
    logic        r_hold_full, r_first, r_miso, r_miso_oe, r_frame_done;
    logic [15:0] r_byte_count;
    logic        r_rx_overflow, r_tx_underrun;
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [8:0]  r_mem [RX_FIFO_DEPTH];

    logic w_start, w_stop, w_sclk_rise, w_sclk_fall;
    logic w_load, w_shift, w_push, w_push_ok, w_pop, w_empty, w_full;
    logic [7:0] w_rx_byte;
    logic [8:0] w_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_sclk_d <= 1'b0;
            r_ncs_d  <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_sclk_d <= w_sclk;
            r_ncs_d  <= w_ncs;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_stop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ncs_d && !w_ncs) begin
                    w_state_next = ST_ACTIVE;
                    w_start      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!r_ncs_d && w_ncs) begin
                    w_state_next = ST_IDLE;
                    w_stop       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // SCLK edges only count inside a frame while synchronised ncs is still low
    assign w_sclk_rise = (r_state == ST_ACTIVE) && !w_ncs && w_sclk && !r_sclk_d;
    assign w_sclk_fall = (r_state == ST_ACTIVE) && !w_ncs && !w_sclk && r_sclk_d;
    assign w_load      = w_start || (w_sclk_fall && (r_bit_cnt == 3'd0));
    assign w_shift     = w_sclk_fall && (r_bit_cnt != 3'd0);
    assign w_push      = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_rx_byte   = {r_rx_shift[6:0], w_mosi};

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = !w_empty && rx_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= {r_first, w_rx_byte};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_first       <= 1'b0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_byte_count  <= '0;
            r_rx_overflow <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_frame_done <= w_stop;
            if (w_start) begin
                r_bit_cnt    <= '0;
                r_byte_count <= '0;
                r_first      <= 1'b1;
                r_miso_oe    <= 1'b1;
            end else if (w_stop) begin
                r_bit_cnt <= '0;
                r_miso_oe <= 1'b0;
            end else if (w_sclk_rise) begin
                r_rx_shift <= w_rx_byte;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (w_push) begin
                    r_first <= 1'b0;
                    if (r_byte_count != 16'hFFFF) r_byte_count <= r_byte_count + 16'd1;
                end
            end

            // A hold write in the same cycle as a load lands after the load has sampled it
            if (w_load) begin
                if (r_hold_full) begin
                    r_tx_shift <= r_hold;
                    r_miso     <= r_hold[7];
                end else begin
                    r_tx_shift <= DUMMY_BYTE;
                    r_miso     <= DUMMY_BYTE[7];
                end
            end else if (w_shift) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                r_miso     <= r_tx_shift[6];
            end
            if (w_stop) r_miso <= 1'b0;

            if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (tx_valid && !r_hold_full) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end

            if (w_load && !r_hold_full)           r_tx_underrun <= 1'b1;
            else if (clr_status)                  r_tx_underrun <= 1'b0;
            if (w_push && w_full && !w_pop)       r_rx_overflow <= 1'b1;
            else if (clr_status)                  r_rx_overflow <= 1'b0;

            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    assign spi_miso     = r_miso;
    assign spi_miso_oe  = r_miso_oe;
    assign rx_data      = w_empty ? 8'h00 : w_head[7:0];
    assign rx_first     = w_empty ? 1'b0 : w_head[8];
    assign rx_valid     = !w_empty;
    assign tx_ready     = !r_hold_full;
    assign frame_active = (r_state == ST_ACTIVE);
    assign frame_done   = r_frame_done;
    assign byte_count   = r_byte_count;
    assign rx_overflow  = r_rx_overflow;
    assign tx_underrun  = r_tx_underrun;
endmodule

// File: tb/tb_joker_spi_slave.sv
// Bench for joker_spi_slave: a mode-0 host model, a TX feeder and an RX scoreboard
// checking popped bytes against what the host sent.
module tb_joker_spi_slave;
    logic        clk = 1'b0;
    logic        reset, spi_sclk, spi_mosi, spi_ncs, rx_ready, tx_valid, clr_status;
    logic [7:0]  tx_data;
    logic        spi_miso, spi_miso_oe, rx_first, rx_valid, tx_ready;
    logic        frame_active, frame_done, rx_overflow, tx_underrun;
    logic [7:0]  rx_data;
    logic [15:0] byte_count;

    joker_spi_slave dut (
        .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_ncs(spi_ncs), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .rx_data(rx_data), .rx_first(rx_first), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_active(frame_active), .frame_done(frame_done), .byte_count(byte_count),
        .rx_overflow(rx_overflow), .tx_underrun(tx_underrun), .clr_status(clr_status)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    logic [8:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] mosi_buf [32];
    logic [7:0] miso_buf [32];

    typedef struct {
        int          nbytes;
        logic [31:0] mosi;      // byte k at [8k +: 8]
        int          ntx;
        logic [31:0] tx;
        logic [31:0] exp_miso;
        logic [15:0] exp_bc;
        logic        exp_ur;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RX scoreboard: a pop happens at the next posedge when both are high here
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rx_valid && rx_ready) begin
                if (rx_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_unexpected: got 0x%0h, expected nothing", {rx_first, rx_data});
                end else begin
                    e = rx_q.pop_front();
                    chk("rx_pop", {23'd0, rx_first, rx_data}, {23'd0, e});
                end
            end
        end
    end

    // TX feeder: tx_ready seen at the negedge is what the next posedge uses
    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_q.size() != 0 && tx_ready && !reset) begin
                tx_valid = 1'b1;
                tx_data  = tx_q.pop_front();
            end else begin
                tx_valid = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (frame_done) fd_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic set_rx_ready(input logic v);
        @(posedge clk);
        #1 rx_ready = v;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_status = 1'b1;
        @(negedge clk) clr_status = 1'b0;
    endtask

    task automatic spi_frame(input int nbytes, input int lastbits, input int npush);
        int nbits;
        nbits = (nbytes - 1) * 8 + lastbits;
        @(negedge clk);
        spi_ncs  = 1'b0;
        spi_mosi = mosi_buf[0][7];
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_sclk = 1'b1;
            miso_buf[i/8][7-(i%8)] = spi_miso;
            if ((i % 8) == 7 && (i / 8) < npush)
                rx_q.push_back({(i / 8) == 0, mosi_buf[i/8]});
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
            if (i == nbits - 1) spi_ncs = 1'b1;
            else spi_mosi = mosi_buf[(i+1)/8][7-((i+1)%8)];
            repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_rx_drain(input string name);
        for (int t = 0; t < 200 && rx_q.size() != 0; t++) @(negedge clk);
        chk(name, rx_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_miso", spi_miso, 0);
        chk("rst_miso_oe", spi_miso_oe, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_first", rx_first, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_frame_active", frame_active, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_byte_count", byte_count, 0);
        chk("rst_rx_overflow", rx_overflow, 0);
        chk("rst_tx_underrun", tx_underrun, 0);
    endtask

    vec_t vecs [5];
    int   fd0;

    initial begin
        vecs[0] = '{1, 32'h0000003C, 1, 32'h000000A5, 32'h000000A5, 16'd1, 1'b0};
        vecs[1] = '{2, 32'h00002211, 0, 32'h00000000, 32'h0000FFFF, 16'd2, 1'b1};
        vecs[2] = '{3, 32'h00C3C2C1, 3, 32'h00030201, 32'h00030201, 16'd3, 1'b0};
        vecs[3] = '{2, 32'h0000FF00, 1, 32'h0000005A, 32'h0000FF5A, 16'd2, 1'b1};
        vecs[4] = '{4, 32'h817E24E7, 4, 32'h10204080, 32'h10204080, 16'd4, 1'b0};

        reset = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ncs = 1'b1;
        rx_ready = 1'b1; clr_status = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            pulse_clr();
            for (int k = 0; k < vecs[v].ntx; k++) tx_q.push_back(vecs[v].tx[8*k +: 8]);
            if (vecs[v].ntx > 0) begin
                for (int t = 0; t < 50 && tx_ready; t++) @(negedge clk);
                chk("hold_loaded", tx_ready, 0);
            end
            for (int k = 0; k < vecs[v].nbytes; k++) mosi_buf[k] = vecs[v].mosi[8*k +: 8];
            fd0 = fd_cnt;
            spi_frame(vecs[v].nbytes, 8, vecs[v].nbytes);
            $display("frame vec %0d: %0d bytes, byte_count=%0d underrun=%0b", v,
                     vecs[v].nbytes, byte_count, tx_underrun);
            for (int k = 0; k < vecs[v].nbytes; k++)
                chk($sformatf("v%0d_miso%0d", v, k), miso_buf[k], vecs[v].exp_miso[8*k +: 8]);
            chk($sformatf("v%0d_byte_count", v), byte_count, vecs[v].exp_bc);
            chk($sformatf("v%0d_underrun", v), tx_underrun, vecs[v].exp_ur);
            chk($sformatf("v%0d_frame_done", v), fd_cnt - fd0, 1);
            chk($sformatf("v%0d_idle_oe", v), {frame_active, spi_miso_oe, spi_miso}, 0);
            wait_rx_drain($sformatf("v%0d_rx_drain", v));
            if (vecs[v].exp_ur) begin
                pulse_clr();
                chk($sformatf("v%0d_underrun_clr", v), tx_underrun, 0);
            end
        end

        // FIFO fill with the consumer stalled: 17th byte is dropped
        set_rx_ready(1'b0);
        for (int k = 0; k < 17; k++) mosi_buf[k] = 8'(k);
        spi_frame(17, 8, 16);
        $display("overflow frame: 17 bytes, byte_count=%0d overflow=%0b", byte_count, rx_overflow);
        chk("ovf_flag", rx_overflow, 1);
        chk("ovf_valid", rx_valid, 1);
        chk("ovf_byte_count", byte_count, 17);
        set_rx_ready(1'b1);
        wait_rx_drain("ovf_drain");
        @(negedge clk);
        chk("ovf_empty", rx_valid, 0);
        pulse_clr();
        chk("ovf_clr", rx_overflow, 0);

        // Aborted 5-bit frame, then a full byte
        mosi_buf[0] = 8'hB7;
        fd0 = fd_cnt;
        spi_frame(1, 5, 0);
        $display("partial frame: 5 bits, byte_count=%0d", byte_count);
        chk("part_byte_count", byte_count, 0);
        chk("part_frame_done", fd_cnt - fd0, 1);
        chk("part_no_push", rx_valid, 0);
        mosi_buf[0] = 8'h81;
        spi_frame(1, 8, 1);
        $display("frame after partial: 0x81, byte_count=%0d", byte_count);
        wait_rx_drain("part_next_rx");
        chk("part_next_bc", byte_count, 1);

        // Reset in the middle of a byte
        @(negedge clk);
        spi_ncs = 1'b0; spi_mosi = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            spi_sclk = 1'b1; repeat (4) @(negedge clk);
            spi_sclk = 1'b0; repeat (4) @(negedge clk);
        end
        fd0 = fd_cnt;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        spi_ncs = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        $display("reset mid-byte: frame_active=%0b rx_valid=%0b", frame_active, rx_valid);
        chk("rst_no_frame_done", fd_cnt - fd0, 0);
        chk("rst_no_push", rx_valid, 0);
        mosi_buf[0] = 8'h5A;
        spi_frame(1, 8, 1);
        $display("frame after reset: 0x5A, byte_count=%0d", byte_count);
        wait_rx_drain("rst_next_rx");
        chk("rst_next_bc", byte_count, 1);
        chk("rst_next_miso", miso_buf[0], 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
